// File: rtl/proc_pipe_pkg.sv
// Shared pipeline types: default datapath/regfile widths and the MEM/WB payload.
package proc_pipe_pkg;

  localparam int unsigned PROC_DATA_WIDTH        = 16;
  localparam int unsigned PROC_REGFILE_LOG2_DEEP = 5;

  localparam logic [PROC_REGFILE_LOG2_DEEP-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                              reg_write_en;
    logic                              mem_to_reg;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] addr;
    logic [PROC_DATA_WIDTH-1:0]        alu;
    logic [PROC_DATA_WIDTH-1:0]        mem_data;
  } memwb_payload_t;

  // Occupancy of a 2-entry skid buffer, encoded as {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush and a
// sideband bit whose output register is pre-qualified by the output valid.
module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  input  logic         s_qual_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o,
  output logic         m_qual_o
);
  import proc_pipe_pkg::*;

  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_main_valid;
  logic         r_skid_valid;
  logic         r_main_q;
  logic         r_skid_q;
  logic         r_s_ready;

  skid_state_e  w_state;
  logic         w_accept;
  logic         w_present;
  logic         w_main_load;
  logic         w_skid_load;
  logic [W-1:0] w_main_din;
  logic         w_main_din_q;
  logic         w_main_valid_nxt;
  logic         w_skid_valid_nxt;

  assign w_state   = skid_state_e'({r_skid_valid, r_main_valid});
  assign w_accept  = s_valid_i & r_s_ready;
  assign w_present = r_main_valid & m_ready_i;

  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_din       = s_data_i;
    w_main_din_q     = s_qual_i;
    if (flush_i) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else begin
      case (w_state)
        SKID_EMPTY: begin
          if (w_accept) begin
            w_main_load      = 1'b1;
            w_main_valid_nxt = 1'b1;
          end
        end
        SKID_ONE: begin
          if (w_accept && w_present) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load      = 1'b1;
            w_skid_valid_nxt = 1'b1;
          end else if (w_present) begin
            w_main_valid_nxt = 1'b0;
          end
        end
        SKID_FULL: begin
          // s_ready is low here, so the only event is draining skid into main
          if (w_present) begin
            w_main_load      = 1'b1;
            w_main_din       = r_skid;
            w_main_din_q     = r_skid_q;
            w_skid_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_main_valid_nxt = 1'b0;
          w_skid_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_q     <= 1'b0;
      r_skid_q     <= 1'b0;
      r_s_ready    <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_s_ready    <= ~w_skid_valid_nxt;
      r_main_q     <= w_main_valid_nxt & (w_main_load ? w_main_din_q : r_main_q);
      if (w_main_load) begin
        r_main <= w_main_din;
      end
      if (w_skid_load) begin
        r_skid   <= s_data_i;
        r_skid_q <= s_qual_i;
      end
    end
  end

  assign s_ready_o = r_s_ready;
  assign m_valid_o = r_main_valid;
  assign m_data_o  = r_main;
  assign m_qual_o  = r_main_q;

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage: skid-buffered payload with x0 write suppression.
// Define MEMWB_WB_MUX_EN to add the registered writeback-data mux output wb_data_o.
module memwb_skid_stage #(
  parameter int unsigned PROC_DATA_WIDTH        = proc_pipe_pkg::PROC_DATA_WIDTH,
  parameter int unsigned PROC_REGFILE_LOG2_DEEP = proc_pipe_pkg::PROC_REGFILE_LOG2_DEEP,
  parameter bit          ZERO_REG_HARDWIRED     = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic                              reg_write_en_i,
  input  logic                              mem_to_reg_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
  input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
  input  logic [PROC_DATA_WIDTH-1:0]        mem_data_i,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic                              reg_write_en_o,
  output logic                              mem_to_reg_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        alu_o,
`ifdef MEMWB_WB_MUX_EN
  output logic [PROC_DATA_WIDTH-1:0]        mem_data_o,
  output logic [PROC_DATA_WIDTH-1:0]        wb_data_o
`else
  output logic [PROC_DATA_WIDTH-1:0]        mem_data_o
`endif
);
  import proc_pipe_pkg::*;

  localparam int unsigned PW = $bits(memwb_payload_t);
`ifdef MEMWB_WB_MUX_EN
  localparam int unsigned BW = PW - 1 + PROC_DATA_WIDTH;
`else
  localparam int unsigned BW = PW - 1;
`endif

  memwb_payload_t w_in;
  logic           w_is_x0;
  logic [BW-1:0]  w_s_data;
  logic [BW-1:0]  w_m_data;

  assign w_is_x0 = ZERO_REG_HARDWIRED && (reg_write_addr_i == REG_ZERO);

  always_comb begin
    w_in              = '0;
    w_in.reg_write_en = reg_write_en_i & ~w_is_x0;
    w_in.mem_to_reg   = mem_to_reg_i;
    w_in.addr         = reg_write_addr_i;
    w_in.alu          = alu_i;
    w_in.mem_data     = mem_data_i;
  end

  // The write enable rides the buffer's qualified sideband so the output
  // register already includes the m_valid_o gating.
`ifdef MEMWB_WB_MUX_EN
  assign w_s_data = {w_in.mem_to_reg, w_in.addr, w_in.alu, w_in.mem_data,
                     (mem_to_reg_i ? mem_data_i : alu_i)};
  assign {mem_to_reg_o, reg_write_addr_o, alu_o, mem_data_o, wb_data_o} = w_m_data;
`else
  assign w_s_data = {w_in.mem_to_reg, w_in.addr, w_in.alu, w_in.mem_data};
  assign {mem_to_reg_o, reg_write_addr_o, alu_o, mem_data_o} = w_m_data;
`endif

  pipe_skid_buf #(
    .W (BW)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (w_s_data),
    .s_qual_i  (w_in.reg_write_en),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (w_m_data),
    .m_qual_o  (reg_write_en_o)
  );

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Self-checking bench for memwb_skid_stage: scoreboard of accepted beats plus per-scenario checks.
module tb_memwb_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic        we_i;
  logic        m2r_i;
  logic [4:0]  addr_i;
  logic [15:0] alu_i;
  logic [15:0] mem_i;
  logic        m_valid;
  logic        m_ready;
  logic        we_o;
  logic        m2r_o;
  logic [4:0]  addr_o;
  logic [15:0] alu_o;
  logic [15:0] mem_o;
`ifdef MEMWB_WB_MUX_EN
  logic [15:0] wb_o;
`endif

  typedef struct packed {
    logic        we;
    logic        m2r;
    logic [4:0]  addr;
    logic [15:0] alu;
    logic [15:0] mem;
  } beat_t;

  beat_t sb_q[$];
  beat_t exp_b;
  beat_t push_b;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_pops   = 0;

  always #5 clk = ~clk;

  memwb_skid_stage dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .s_valid_i        (s_valid),
    .s_ready_o        (s_ready),
    .reg_write_en_i   (we_i),
    .mem_to_reg_i     (m2r_i),
    .reg_write_addr_i (addr_i),
    .alu_i            (alu_i),
    .mem_data_i       (mem_i),
    .m_valid_o        (m_valid),
    .m_ready_i        (m_ready),
    .reg_write_en_o   (we_o),
    .mem_to_reg_o     (m2r_o),
    .reg_write_addr_o (addr_o),
    .alu_o            (alu_o),
`ifdef MEMWB_WB_MUX_EN
    .mem_data_o       (mem_o),
    .wb_data_o        (wb_o)
`else
    .mem_data_o       (mem_o)
`endif
  );

  always @(negedge rst_n) sb_q.delete();

  // Scoreboard: pop/compare on presentation, push on accept, both sampled at negedge.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (m_valid && m_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got beat alu=%h addr=%0d, required no beat", alu_o, addr_o);
        end else begin
          exp_b = sb_q.pop_front();
          n_pops++;
          if ({we_o, m2r_o, addr_o, alu_o, mem_o} !== exp_b) begin
            n_fail++;
            $display("FAIL beat_payload: got %h, required %h", {we_o, m2r_o, addr_o, alu_o, mem_o}, exp_b);
          end
`ifdef MEMWB_WB_MUX_EN
          n_checks++;
          if (wb_o !== (exp_b.m2r ? exp_b.mem : exp_b.alu)) begin
            n_fail++;
            $display("FAIL beat_wb_data: got %h, required %h", wb_o, (exp_b.m2r ? exp_b.mem : exp_b.alu));
          end
`endif
        end
      end
      if (s_valid && s_ready) begin
        push_b.we   = we_i && (addr_i != 5'd0);
        push_b.m2r  = m2r_i;
        push_b.addr = addr_i;
        push_b.alu  = alu_i;
        push_b.mem  = mem_i;
        sb_q.push_back(push_b);
      end
    end
  end

  task automatic drive_beat(input logic we, input logic m2r, input logic [4:0] addr,
                            input logic [15:0] alu, input logic [15:0] mem);
    s_valid = 1'b1;
    we_i    = we;
    m2r_i   = m2r;
    addr_i  = addr;
    alu_i   = alu;
    mem_i   = mem;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b, required 1", s_ready); end
    n_checks++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, required 0", we_o); end
    n_checks++; if (m2r_o !== 1'b0) begin n_fail++; $display("FAIL reset_m2r: got %b, required 0", m2r_o); end
    n_checks++; if (addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", addr_o); end
    n_checks++; if (alu_o !== 16'h0) begin n_fail++; $display("FAIL reset_alu: got %h, required 0", alu_o); end
    n_checks++; if (mem_o !== 16'h0) begin n_fail++; $display("FAIL reset_mem: got %h, required 0", mem_o); end
`ifdef MEMWB_WB_MUX_EN
    n_checks++; if (wb_o !== 16'h0) begin n_fail++; $display("FAIL reset_wb: got %h, required 0", wb_o); end
`endif
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    int vcnt  = 0;
    int first = -1;
    int last  = -1;
    int pops0 = n_pops;
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (i < 8) drive_beat(1'b1, 1'b0, 5'(i + 1), 16'(i + 1), 16'h0);
      else s_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (s_ready !== 1'b1) begin n_fail++; $display("FAIL stream_s_ready: cycle %0d got %b, required 1", i, s_ready); end
      if (m_valid) begin
        vcnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    n_checks++; if (first !== 1) begin n_fail++; $display("FAIL stream_latency: first valid cycle %0d, required 1", first); end
    n_checks++; if (vcnt !== 8 || (last - first + 1) !== 8) begin n_fail++; $display("FAIL stream_contiguous: got %0d valid over span %0d, required 8 over 8", vcnt, last - first + 1); end
    n_checks++; if ((n_pops - pops0) !== 8) begin n_fail++; $display("FAIL stream_count: got %0d beats, required 8", n_pops - pops0); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    next_cycle(); drive_beat(1'b1, 1'b0, 5'd3, 16'h00AA, 16'h1111);
    next_cycle(); drive_beat(1'b1, 1'b1, 5'd4, 16'h00BB, 16'h2222);
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1 || m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_one_state: got s_ready=%b m_valid=%b, required 1 1", s_ready, m_valid); end
    next_cycle(); s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_s_ready: got %b, required 0", s_ready); end
      n_checks++; if (m_valid !== 1'b1 || alu_o !== 16'h00AA) begin n_fail++; $display("FAIL bp_hold: got valid=%b alu=%h, required 1 00aa", m_valid, alu_o); end
      next_cycle();
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (alu_o !== 16'h00AA) begin n_fail++; $display("FAIL bp_first_out: got %h, required 00aa", alu_o); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (alu_o !== 16'h00BB || m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_out: got valid=%b alu=%h, required 1 00bb", m_valid, alu_o); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b, required 1", s_ready); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b, required 0", m_valid); end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    next_cycle(); drive_beat(1'b1, 1'b0, 5'd6, 16'h0C01, 16'h0);
    next_cycle(); drive_beat(1'b1, 1'b0, 5'd7, 16'h0D01, 16'h0);
    next_cycle(); drive_beat(1'b1, 1'b0, 5'd8, 16'h0E01, 16'h0); flush = 1'b1;
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_full: got s_ready=%b, required 0", s_ready); end
    next_cycle(); flush = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_empty: got m_valid=%b s_ready=%b, required 0 1", m_valid, s_ready); end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_stale: got m_valid=%b alu=%h, required 0", m_valid, alu_o); end
    end
    m_ready = 1'b0;
    next_cycle(); drive_beat(1'b1, 1'b0, 5'd9, 16'h0F01, 16'h0);
    next_cycle(); drive_beat(1'b1, 1'b0, 5'd10, 16'h0F02, 16'h0); flush = 1'b1;
    next_cycle(); flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL flush_one_accept: got m_valid=%b s_ready=%b, required 0 1", m_valid, s_ready); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_beat: got m_valid=%b alu=%h, required 0", m_valid, alu_o); end
  endtask

  task automatic test_x0_write();
    m_ready = 1'b0;
    next_cycle(); drive_beat(1'b1, 1'b0, 5'd0, 16'h1234, 16'h0);
    next_cycle(); s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b1 || alu_o !== 16'h1234) begin n_fail++; $display("FAIL x0_beat: got valid=%b alu=%h, required 1 1234", m_valid, alu_o); end
    n_checks++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL x0_we_suppressed: got %b, required 0", we_o); end
    next_cycle(); m_ready = 1'b1; drive_beat(1'b1, 1'b0, 5'd5, 16'h1234, 16'h0);
    next_cycle(); m_ready = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b1 || addr_o !== 5'd5) begin n_fail++; $display("FAIL x5_beat: got valid=%b addr=%0d, required 1 5", m_valid, addr_o); end
    n_checks++; if (we_o !== 1'b1) begin n_fail++; $display("FAIL x5_we: got %b, required 1", we_o); end
    next_cycle(); m_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0 || we_o !== 1'b0) begin n_fail++; $display("FAIL we_gated_by_valid: got valid=%b we=%b, required 0 0", m_valid, we_o); end
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    next_cycle(); drive_beat(1'b1, 1'b1, 5'd11, 16'h0A0A, 16'h5A5A);
    next_cycle(); drive_beat(1'b1, 1'b0, 5'd12, 16'h0B0B, 16'h6B6B);
    next_cycle(); s_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL arst_handshake: got m_valid=%b s_ready=%b, required 0 1", m_valid, s_ready); end
    n_checks++; if ({we_o, m2r_o, addr_o, alu_o, mem_o} !== 39'h0) begin n_fail++; $display("FAIL arst_outputs: got %h, required 0", {we_o, m2r_o, addr_o, alu_o, mem_o}); end
    next_cycle();
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_stale: got m_valid=%b alu=%h, required 0", m_valid, alu_o); end
      next_cycle();
    end
    drive_beat(1'b1, 1'b0, 5'd13, 16'h0C0C, 16'h0);
    next_cycle(); s_valid = 1'b0;
    next_cycle();
  endtask

`ifdef MEMWB_WB_MUX_EN
  task automatic test_wb_mux();
    m_ready = 1'b0;
    next_cycle(); drive_beat(1'b1, 1'b1, 5'd14, 16'h0042, 16'hBEEF);
    next_cycle(); s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (wb_o !== 16'hBEEF) begin n_fail++; $display("FAIL wb_mux_load: got %h, required beef", wb_o); end
    next_cycle(); m_ready = 1'b1; drive_beat(1'b1, 1'b0, 5'd14, 16'h0042, 16'hBEEF);
    next_cycle(); m_ready = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (wb_o !== 16'h0042) begin n_fail++; $display("FAIL wb_mux_alu: got %h, required 0042", wb_o); end
    next_cycle(); m_ready = 1'b1;
    next_cycle();
  endtask
`endif

  task automatic test_back_to_back();
    int unsigned qs;
    for (int i = 0; i < 80; i++) begin
      next_cycle();
      qs = sb_q.size();
      n_checks++; if (s_ready !== (qs < 2)) begin n_fail++; $display("FAIL rand_s_ready: cycle %0d got %b, required %b", i, s_ready, (qs < 2)); end
      n_checks++; if (m_valid !== (qs > 0)) begin n_fail++; $display("FAIL rand_m_valid: cycle %0d got %b, required %b", i, m_valid, (qs > 0)); end
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) != 0)
        drive_beat(1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom));
      else
        s_valid = 1'b0;
    end
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (4) next_cycle();
    n_checks++; if (sb_q.size() != 0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drain: got %0d beats left valid=%b, required 0 0", sb_q.size(), m_valid); end
  endtask

  initial begin
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    we_i = 1'b0; m2r_i = 1'b0; addr_i = '0; alu_i = '0; mem_i = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_x0_write();
    test_async_reset();
`ifdef MEMWB_WB_MUX_EN
    test_wb_mux();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
